// File: rtl/instr_stream_rx.sv
// Instruction stream receiver. It assembles WORDS tagged AXI-Stream beats into
// one wide instruction and checks that the beat tags arrive in order. Beats that
// arrive out of order are dropped and the receiver resynchronises. A finished
// instruction is offered to the decoder over a valid/ready port.
module instr_stream_rx #(
    parameter int unsigned           DATA_WIDTH = 64,
    parameter int unsigned           WORDS      = 8,
    parameter int unsigned           TAG_WIDTH  = 4,
    parameter logic [TAG_WIDTH-1:0]  TAG_BASE   = 4'h8,
    parameter int unsigned           CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_axis_instr_tvalid,
    output logic                        s_axis_instr_tready,
    input  logic [DATA_WIDTH-1:0]       s_axis_instr_tdata,
    output logic                        m_instr_valid,
    input  logic                        m_instr_ready,
    output logic [WORDS*DATA_WIDTH-1:0] m_instr_data,
    output logic [CNT_WIDTH-1:0]        instr_cnt,
    output logic [CNT_WIDTH-1:0]        err_cnt,
    output logic                        err_flag
);

    localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned LAST  = WORDS - 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [TAG_WIDTH-1:0] tag;
    logic [TAG_WIDTH-1:0] exp_tag;
    logic                 beat_fire;
    logic                 hand_off;
    logic                 tag_ok;
    logic                 tag_err;
    logic                 restart;
    logic                 last_word;

    // While an instruction is being held, a beat can only be taken in the cycle the decoder accepts it.
    assign s_axis_instr_tready = (state != HOLD) || m_instr_ready;

    // Beat decode. idx is zero outside COLLECT, so the expected tag is TAG_BASE there.
    always_comb begin
        tag       = s_axis_instr_tdata[DATA_WIDTH-1 -: TAG_WIDTH];
        exp_tag   = TAG_BASE + TAG_WIDTH'(idx);
        beat_fire = s_axis_instr_tvalid && s_axis_instr_tready;
        hand_off  = (state == HOLD) && m_instr_ready;
        tag_ok    = beat_fire && (tag == exp_tag);
        tag_err   = beat_fire && (tag != exp_tag);
        restart   = tag_err && (state == COLLECT) && (tag == TAG_BASE);
        last_word = (idx == IDX_W'(LAST));
    end

    // Sequencing FSM and beat index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else if (tag_ok) begin
            if (last_word) begin
                state <= HOLD;
                idx   <= '0;
            end else begin
                state <= COLLECT;
                idx   <= idx + IDX_W'(1);
            end
        end else if (restart) begin
            state <= COLLECT;
            idx   <= IDX_W'(1);
        end else if (tag_err || hand_off) begin
            state <= IDLE;
            idx   <= '0;
        end
    end

    // Word storage; written only by accepted beats, so it stays stable while the instruction is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_instr_data <= '0;
        end else if (tag_ok) begin
            m_instr_data[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= s_axis_instr_tdata;
        end else if (restart) begin
            m_instr_data[DATA_WIDTH-1:0] <= s_axis_instr_tdata;
        end
    end

    // Instruction valid rises the cycle after the last beat and drops when the decoder takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_instr_valid <= 1'b0;
        end else if (tag_ok && last_word) begin
            m_instr_valid <= 1'b1;
        end else if (hand_off) begin
            m_instr_valid <= 1'b0;
        end
    end

    // Hand-off counter; wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_cnt <= '0;
        end else if (hand_off) begin
            instr_cnt <= instr_cnt + CNT_WIDTH'(1);
        end
    end

    // Tag error counter (saturating) and sticky error flag; one event per offending beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt  <= '0;
            err_flag <= 1'b0;
        end else if (tag_err) begin
            err_flag <= 1'b1;
            if (err_cnt != {CNT_WIDTH{1'b1}}) begin
                err_cnt <= err_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_stream_rx.sv
// Directed bench for instr_stream_rx. A scoreboard queue receives each expected
// instruction when its beats are driven, and a monitor compares against it when the DUT offers it.
module tb_instr_stream_rx;

    localparam int unsigned DW    = 64;
    localparam int unsigned WORDS = 8;
    localparam int unsigned CW    = 16;
    localparam int unsigned IW    = DW * WORDS;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_axis_instr_tvalid;
    logic          s_axis_instr_tready;
    logic [DW-1:0] s_axis_instr_tdata;
    logic          m_instr_valid;
    logic          m_instr_ready;
    logic [IW-1:0] m_instr_data;
    logic [CW-1:0] instr_cnt;
    logic [CW-1:0] err_cnt;
    logic          err_flag;

    int errors       = 0;
    int checks       = 0;
    int delivered    = 0;
    int stall_cycles = 0;

    logic [IW-1:0] sb[$];
    logic [DW-1:0] t1w [WORDS] = '{
        64'h8001022801390199, 64'h9200400093000126,
        64'ha0020004050002df, 64'hb002df0341000cc8,
        64'hc000000705001b08, 64'hd000310016900000,
        64'he000000016860000, 64'hf000000016d00000
    };

    instr_stream_rx dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .s_axis_instr_tvalid (s_axis_instr_tvalid),
        .s_axis_instr_tready (s_axis_instr_tready),
        .s_axis_instr_tdata  (s_axis_instr_tdata),
        .m_instr_valid       (m_instr_valid),
        .m_instr_ready       (m_instr_ready),
        .m_instr_data        (m_instr_data),
        .instr_cnt           (instr_cnt),
        .err_cnt             (err_cnt),
        .err_flag            (err_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [IW-1:0] pack_words(input logic [DW-1:0] w [WORDS]);
        logic [IW-1:0] p;
        for (int k = 0; k < WORDS; k++) p[k*DW +: DW] = w[k];
        return p;
    endfunction

    function automatic logic [IW-1:0] make_pkt();
        logic [IW-1:0] p;
        logic [DW-1:0] w;
        for (int k = 0; k < WORDS; k++) begin
            w = {$urandom, $urandom};
            w[DW-1 -: 4] = 4'(8 + k);
            p[k*DW +: DW] = w;
        end
        return p;
    endfunction

    // Drive one beat and wait for its handshake; returns #1 after the accepting edge.
    task automatic send_beat(input logic [DW-1:0] d);
        int n;
        n = 0;
        s_axis_instr_tvalid = 1'b1;
        s_axis_instr_tdata  = d;
        @(negedge clk);
        while (!s_axis_instr_tready && n < 200) begin
            n++;
            stall_cycles++;
            @(negedge clk);
        end
        if (!s_axis_instr_tready) begin
            checks++;
            errors++;
            $error("FAIL beat_timeout: observed tready=0 expected handshake within 200 cycles");
        end
        @(posedge clk);
        #1;
        s_axis_instr_tvalid = 1'b0;
    endtask

    task automatic send_packet(input logic [IW-1:0] p);
        for (int k = 0; k < WORDS; k++) send_beat(p[k*DW +: DW]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_axis_instr_tvalid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare the offered instruction to the queue head, pop on hand-off.
    always @(negedge clk) begin
        if (rst_n && m_instr_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_instr: observed %0h expected none", m_instr_data);
            end
            if (sb.size() != 0) begin
                check("instr_data", m_instr_data, sb[0]);
                if (m_instr_ready) begin
                    void'(sb.pop_front());
                    delivered++;
                end
            end
        end
    end

    initial begin
        logic [IW-1:0] p1, p2, p5, p6, p7, p8;
        logic [DW-1:0] w5 [WORDS];
        int s0, d0;

        rst_n               = 1'b0;
        s_axis_instr_tvalid = 1'b0;
        s_axis_instr_tdata  = '0;
        m_instr_ready       = 1'b1;
        p1 = pack_words(t1w);

        // Reset values
        #12;
        check("rst_valid", m_instr_valid, 0);
        check("rst_data", m_instr_data, 0);
        check("rst_instr_cnt", instr_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_err_flag", err_flag, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_after_reset", s_axis_instr_tready, 1);

        // T1: single packet, latency and counters
        sb.push_back(p1);
        for (int k = 0; k < WORDS - 1; k++) send_beat(t1w[k]);
        check("t1_valid_before_last", m_instr_valid, 0);
        send_beat(t1w[WORDS-1]);
        check("t1_valid_latency", m_instr_valid, 1);
        idle(1);
        check("t1_valid_drop", m_instr_valid, 0);
        check("t1_instr_cnt", instr_cnt, 1);
        check("t1_err_flag", err_flag, 0);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_delivered", delivered, 1);

        // T2: 8 back-to-back packets with the decoder always ready
        do_reset();
        s0 = stall_cycles;
        d0 = delivered;
        for (int i = 0; i < 8; i++) begin
            p2 = make_pkt();
            sb.push_back(p2);
            send_packet(p2);
        end
        idle(1);
        check("t2_no_stall", stall_cycles - s0, 0);
        check("t2_pulses", delivered - d0, 8);
        check("t2_instr_cnt", instr_cnt, 8);
        check("t2_err_cnt", err_cnt, 0);

        // T3: decoder stalls 20 cycles while the next packet waits
        do_reset();
        m_instr_ready = 1'b0;
        sb.push_back(p1);
        send_packet(p1);
        check("t3_valid_held", m_instr_valid, 1);
        p2 = make_pkt();
        sb.push_back(p2);
        s0 = stall_cycles;
        fork
            send_packet(p2);
            begin
                @(posedge clk);
                #1;
                check("t3_tready_low", s_axis_instr_tready, 0);
                check("t3_instr_cnt_stalled", instr_cnt, 0);
                repeat (19) @(posedge clk);
                #1;
                m_instr_ready = 1'b1;
            end
        join
        check("t3_stall_len", stall_cycles - s0, 20);
        check("t3_valid_p2", m_instr_valid, 1);
        idle(1);
        check("t3_instr_cnt", instr_cnt, 2);

        // T4: misaligned leading beat dropped, tvalid gap mid-packet
        do_reset();
        sb.push_back(p1);
        send_beat(t1w[1]);
        check("t4_err_cnt_first", err_cnt, 1);
        check("t4_err_flag", err_flag, 1);
        for (int k = 0; k < 4; k++) send_beat(t1w[k]);
        idle(5);
        check("t4_valid_in_gap", m_instr_valid, 0);
        for (int k = 4; k < WORDS; k++) send_beat(t1w[k]);
        idle(1);
        check("t4_instr_cnt", instr_cnt, 1);
        check("t4_err_cnt", err_cnt, 1);

        // T5: restart on a beat-0 tag mid-packet, then drop to IDLE on a wrong tag
        do_reset();
        w5 = t1w;
        w5[0] = 64'h8001021c01320320;
        p5 = pack_words(w5);
        sb.push_back(p5);
        send_beat(t1w[0]);
        send_beat(t1w[1]);
        send_beat(t1w[2]);
        send_beat(w5[0]);
        check("t5_err_restart", err_cnt, 1);
        for (int k = 1; k < WORDS; k++) send_beat(w5[k]);
        idle(1);
        check("t5_instr_cnt", instr_cnt, 1);
        check("t5_err_cnt", err_cnt, 1);
        send_beat(t1w[0]);
        send_beat(t1w[1]);
        send_beat(t1w[4]);
        check("t5_err_drop", err_cnt, 2);
        p6 = make_pkt();
        sb.push_back(p6);
        send_packet(p6);
        idle(1);
        check("t5_instr_cnt_after_idle", instr_cnt, 2);
        check("t5_err_cnt_after_idle", err_cnt, 2);

        // T6: asynchronous reset mid-packet, then a fresh packet
        p7 = make_pkt();
        for (int k = 0; k < 4; k++) send_beat(p7[k*DW +: DW]);
        rst_n = 1'b0;
        #1;
        check("t6_valid", m_instr_valid, 0);
        check("t6_data", m_instr_data, 0);
        check("t6_instr_cnt", instr_cnt, 0);
        check("t6_err_cnt", err_cnt, 0);
        check("t6_err_flag", err_flag, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        p8 = make_pkt();
        sb.push_back(p8);
        send_packet(p8);
        idle(1);
        check("t6_instr_cnt_fresh", instr_cnt, 1);
        check("t6_err_cnt_fresh", err_cnt, 0);

        // Everything pushed must have been delivered
        idle(2);
        check("sb_empty", sb.size(), 0);
        check("delivered_total", delivered, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
